// File: rtl/sos_pkg.sv
// Shared types and width helper for the speed-of-sound distance calculator.
// SOS_ABS_ENERGY_EN selects |x| sample energy (narrower accumulator) over x*x.
package sos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    AWAIT,
    ANALYZE,
    HOLDOFF
  } sos_state_t;

  function automatic int unsigned energy_w(input int unsigned window_size);
`ifdef SOS_ABS_ENERGY_EN
    return 16 + $clog2(window_size);
`else
    return 32 + $clog2(window_size);
`endif
  endfunction

endpackage

// File: rtl/impulse_generator.sv
// Emits one full-scale impulse sample on the first step after a request,
// flagging the impulse sample with a one-cycle start strobe.
module impulse_generator #(
  parameter logic signed [15:0] PEAK = 16'sh7fff
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               step_in,
  input  logic               req_in,
  output logic               start_out,
  output logic signed [15:0] amp_out
);

  logic armed;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed     <= 1'b0;
      start_out <= 1'b0;
      amp_out   <= '0;
    end else begin
      start_out <= 1'b0;
      if (step_in) begin
        if (armed) begin
          amp_out   <= PEAK;
          start_out <= 1'b1;
          armed     <= 1'b0;
        end else begin
          amp_out <= '0;
        end
      end
      if (req_in) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/sos_onset_detector.sv
// Per-channel windowed energy onset detector with round-to-round confirmation.
// SOS_ABS_ENERGY_EN selects |x| energy (no multiplier) instead of x*x.
module sos_onset_detector
  import sos_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE   = 16,
  parameter int unsigned DELAY_W       = 12,
  parameter int unsigned CONFIRM_COUNT = 3,
  parameter int unsigned TOLERANCE     = 0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               clear_all,
  input  logic               clear_round,
  input  logic               step,
  input  logic               win_last,
  input  logic [DELAY_W-1:0] cnt_next,
  input  logic               round_end,
  input  logic signed [15:0] sample,
  output logic               latched,
  output logic [DELAY_W-1:0] delay,
  output logic               valid
);

  localparam int unsigned EW  = energy_w(WINDOW_SIZE);
  localparam int unsigned MCW = $clog2(CONFIRM_COUNT + 1);

  logic [EW-1:0]      energy, total, sum, prev, prev2;
  logic [DELAY_W-1:0] onset_t, last_t, diff;
  logic [MCW-1:0]     match_cnt, match_nxt;
  logic               onset;

`ifdef SOS_ABS_ENERGY_EN
  logic [15:0] mag;
  assign mag    = sample[15] ? 16'(-sample) : 16'(sample);
  assign energy = EW'(mag);
`else
  logic signed [31:0] square;
  assign square = 32'(sample) * 32'(sample);
  assign energy = EW'($unsigned(square));
`endif

  // Doubled references are one bit wider so the all-ones seed never wraps.
  assign total = sum + energy;
  assign onset = ({1'b0, total} > {prev, 1'b0}) && ({1'b0, total} > {prev2, 1'b0});
  assign diff  = (onset_t >= last_t) ? onset_t - last_t : last_t - onset_t;

  always_comb begin
    match_nxt = '0;
    if (latched) begin
      if (diff <= DELAY_W'(TOLERANCE))
        match_nxt = (match_cnt == MCW'(CONFIRM_COUNT)) ? match_cnt : match_cnt + MCW'(1);
      else
        match_nxt = MCW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum       <= '0;
      prev      <= '0;
      prev2     <= '0;
      latched   <= 1'b0;
      onset_t   <= '0;
      last_t    <= '0;
      match_cnt <= '0;
      delay     <= '0;
      valid     <= 1'b0;
    end else begin
      if (clear_all) begin
        last_t    <= '0;
        match_cnt <= '0;
        valid     <= 1'b0;
      end
      if (clear_round) begin
        sum     <= '0;
        prev    <= '1;
        prev2   <= '1;
        latched <= 1'b0;
        onset_t <= '0;
      end else if (step && !latched) begin
        if (!win_last) begin
          sum <= total;
        end else if (onset) begin
          latched <= 1'b1;
          onset_t <= cnt_next;
        end else begin
          prev2 <= prev;
          prev  <= total;
          sum   <= '0;
        end
      end
      if (round_end) begin
        match_cnt <= match_nxt;
        if (latched) last_t <= onset_t;
        if (match_nxt == MCW'(CONFIRM_COUNT) && !valid) begin
          delay <= onset_t;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sos_multi_dist_calc.sv
// Round FSM, sample/window counters, impulse generator and NUM_CH onset detectors.
// SOS_ABS_ENERGY_EN selects |x| sample energy in the detectors.
module sos_multi_dist_calc
  import sos_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WINDOW_SIZE    = 16,
  parameter int unsigned MAX_DELAY      = 512,
  parameter int unsigned DELAY_W        = 12,
  parameter int unsigned CONFIRM_COUNT  = 3,
  parameter int unsigned TOLERANCE      = 0,
  parameter int unsigned HOLDOFF_CYCLES = 98_300_000,
  parameter int unsigned MAX_ROUNDS     = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        step_in,
  input  logic                        trigger_in,
  input  logic                        abort_in,
  input  logic [NUM_CH*16-1:0]        mic_in,
  output logic signed [15:0]          amp_out,
  output logic [NUM_CH*DELAY_W-1:0]   delay_out,
  output logic [NUM_CH-1:0]           delay_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);

  localparam int unsigned WPW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam int unsigned RCW = $clog2(MAX_ROUNDS + 1);
  localparam int unsigned HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  sos_state_t         state, state_nxt;
  logic [DELAY_W-1:0] sample_cnt;
  logic [WPW-1:0]     win_pos;
  logic [RCW-1:0]     round_cnt;
  logic [HCW-1:0]     hold_cnt;
  logic [NUM_CH-1:0]  latched;
  logic imp_req, imp_start, clear_all, clear_round, round_end, analyze_step;
  logic round_over, win_last, hold_last, finish, finish_to;

  assign busy       = (state != IDLE);
  assign win_last   = (win_pos == WPW'(WINDOW_SIZE - 1));
  assign hold_last  = (hold_cnt == HCW'(HOLDOFF_CYCLES - 1));
  assign round_over = (&latched) || (sample_cnt == DELAY_W'(MAX_DELAY));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    imp_req      = 1'b0;
    clear_all    = 1'b0;
    clear_round  = 1'b0;
    round_end    = 1'b0;
    analyze_step = 1'b0;
    finish       = 1'b0;
    finish_to    = 1'b0;
    case (state)
      IDLE: if (trigger_in) begin
        clear_all = 1'b1;
        state_nxt = START;
      end
      START: begin
        imp_req   = 1'b1;
        state_nxt = AWAIT;
      end
      AWAIT: if (imp_start) begin
        clear_round = 1'b1;
        state_nxt   = ANALYZE;
      end
      ANALYZE: if (round_over) begin
        round_end = 1'b1;
        state_nxt = HOLDOFF;
      end else begin
        analyze_step = step_in;
      end
      HOLDOFF: if (hold_last) begin
        if (&delay_valid) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (round_cnt == RCW'(MAX_ROUNDS)) begin
          finish    = 1'b1;
          finish_to = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = START;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every side effect of the current state, including round end.
    if (state != IDLE && abort_in) begin
      state_nxt    = IDLE;
      imp_req      = 1'b0;
      clear_round  = 1'b0;
      round_end    = 1'b0;
      analyze_step = 1'b0;
      finish       = 1'b0;
      finish_to    = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sample_cnt <= '0;
      win_pos    <= '0;
      round_cnt  <= '0;
      hold_cnt   <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= finish;
      if (clear_all) begin
        round_cnt <= '0;
        timeout   <= 1'b0;
      end else if (imp_req) begin
        round_cnt <= round_cnt + RCW'(1);
      end
      if (finish_to) timeout <= 1'b1;
      if (clear_round) begin
        sample_cnt <= '0;
        win_pos    <= '0;
      end else if (analyze_step) begin
        sample_cnt <= sample_cnt + DELAY_W'(1);
        win_pos    <= win_last ? '0 : win_pos + WPW'(1);
      end
      if (state != HOLDOFF)  hold_cnt <= '0;
      else if (!hold_last)   hold_cnt <= hold_cnt + HCW'(1);
    end
  end

  impulse_generator u_impulse (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .step_in   (step_in),
    .req_in    (imp_req),
    .start_out (imp_start),
    .amp_out   (amp_out)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sos_onset_detector #(
      .WINDOW_SIZE   (WINDOW_SIZE),
      .DELAY_W       (DELAY_W),
      .CONFIRM_COUNT (CONFIRM_COUNT),
      .TOLERANCE     (TOLERANCE)
    ) u_det (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .clear_all   (clear_all),
      .clear_round (clear_round),
      .step        (analyze_step),
      .win_last    (win_last),
      .cnt_next    (sample_cnt + DELAY_W'(1)),
      .round_end   (round_end),
      .sample      ($signed(mic_in[16*c +: 16])),
      .latched     (latched[c]),
      .delay       (delay_out[DELAY_W*c +: DELAY_W]),
      .valid       (delay_valid[c])
    );
  end

endmodule

// File: tb/tb_sos_multi_dist_calc.sv
// Directed bench for sos_multi_dist_calc: burst stimulus per round, with a
// window-energy/round-match model predicting the outcome checked at each done.
module tb_sos_multi_dist_calc;

  localparam int NCH = 2, WS = 16, MD = 256, DW = 12, CC = 3, TOL = 0;
  localparam int HO = 8, MR = 16, SDIV = 4, BUDGET = 30000;

  logic clk_in = 1'b0;
  logic rst_n_in, step_in, trigger_in, abort_in;
  logic [NCH*16-1:0] mic_in;
  logic signed [15:0] amp_out;
  logic [NCH*DW-1:0] delay_out;
  logic [NCH-1:0] delay_valid;
  logic busy, done, timeout;

  int tests = 0, fails = 0;
  int plan_b[1:MR][NCH];
  int plan_a[NCH];
  int blen = 8;
  int samp = 0, imp_total = 0, base = 0, done_cnt = 0;
  logic [NCH-1:0] exp_valid;
  int exp_delay[NCH];
  logic exp_timeout;
  int exp_rounds;

  sos_multi_dist_calc #(
    .NUM_CH(NCH), .WINDOW_SIZE(WS), .MAX_DELAY(MD), .DELAY_W(DW),
    .CONFIRM_COUNT(CC), .TOLERANCE(TOL), .HOLDOFF_CYCLES(HO), .MAX_ROUNDS(MR)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .step_in(step_in), .trigger_in(trigger_in),
    .abort_in(abort_in), .mic_in(mic_in), .amp_out(amp_out), .delay_out(delay_out),
    .delay_valid(delay_valid), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dly(input int c);
    logic [NCH*DW-1:0] v = delay_out;
    return int'(v[c*DW +: DW]);
  endfunction

  function automatic logic [NCH*16-1:0] build(input int r, input int s);
    logic [NCH*16-1:0] v = '0;
    for (int c = 0; c < NCH; c++)
      if (r >= 1 && r <= MR && plan_b[r][c] > 0 && s >= plan_b[r][c] && s < plan_b[r][c] + blen)
        v[c*16 +: 16] = 16'(plan_a[c]);
    return v;
  endfunction

  // Onset sample for a burst: first window (after two reference windows) whose
  // energy exceeds twice each of the previous two windows; 0 means miss.
  function automatic longint onset_of(input int b, input int a, input int len);
    longint prev = -1, pp = -1;
    for (int w = 0; (w + 1) * WS <= MD; w++) begin
      longint s = 0;
      for (int i = 1; i <= WS; i++) begin
        int n = w * WS + i;
        if (b > 0 && n >= b && n < b + len) s += longint'(a) * longint'(a);
      end
      if (prev >= 0 && pp >= 0 && s > 2 * prev && s > 2 * pp) return longint'((w + 1) * WS);
      pp = prev;
      prev = s;
    end
    return 0;
  endfunction

  task automatic run_model();
    int cnt[NCH];
    int last[NCH];
    exp_valid = '0;
    exp_timeout = 1'b0;
    exp_rounds = MR;
    for (int c = 0; c < NCH; c++) begin cnt[c] = 0; last[c] = 0; exp_delay[c] = 0; end
    for (int r = 1; r <= MR; r++) begin
      for (int c = 0; c < NCH; c++) begin
        int t = int'(onset_of(plan_b[r][c], plan_a[c], blen));
        if (t > 0) begin
          int d = (t > last[c]) ? t - last[c] : last[c] - t;
          cnt[c] = (d <= TOL) ? ((cnt[c] + 1 > CC) ? CC : cnt[c] + 1) : 1;
          last[c] = t;
        end else begin
          cnt[c] = 0;
        end
        if (cnt[c] == CC && !exp_valid[c]) begin exp_valid[c] = 1'b1; exp_delay[c] = t; end
      end
      if (&exp_valid) begin exp_rounds = r; break; end
      if (r == MR) exp_timeout = 1'b1;
    end
  endtask

  // Stimulus: step strobe every SDIV clocks, sample index restarts at each impulse.
  initial begin
    int ph = 0;
    logic amp_last = 1'b0;
    step_in = 1'b0;
    mic_in = '0;
    forever begin
      @(negedge clk_in);
      if (amp_out != 0 && !amp_last) begin samp = 0; imp_total++; end
      amp_last = (amp_out != 0);
      ph = (ph + 1) % SDIV;
      if (ph == 0) begin
        samp++;
        step_in = 1'b1;
        mic_in = build(imp_total - base, samp);
      end else begin
        step_in = 1'b0;
      end
    end
  end

  // Compare process: every done pulse is checked against the model.
  initial forever begin
    @(negedge clk_in);
    if (done) begin
      done_cnt++;
      chk("done_valid", delay_valid, exp_valid);
      for (int c = 0; c < NCH; c++)
        if (exp_valid[c]) chk($sformatf("done_delay%0d", c), dly(c), exp_delay[c]);
      chk("done_timeout", timeout, exp_timeout);
      chk("done_rounds", imp_total - base, exp_rounds);
      chk("done_busy", busy, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_all(input int b0, input int b1, input int a0, input int a1, input int len);
    for (int r = 1; r <= MR; r++) begin plan_b[r][0] = b0; plan_b[r][1] = b1; end
    plan_a[0] = a0;
    plan_a[1] = a1;
    blen = len;
  endtask

  task automatic trigger();
    base = imp_total;
    trigger_in = 1'b1;
    tick(1);
    trigger_in = 1'b0;
  endtask

  task automatic wait_rs(input string name, input int r, input int s);
    int n = 0;
    while (!(imp_total - base == r && samp == s) && n < BUDGET) begin tick(1); n++; end
    chk({name, "_reached"}, (n < BUDGET) ? 1 : 0, 1);
  endtask

  task automatic run_scenario(input string name);
    int start = done_cnt;
    int n = 0;
    run_model();
    trigger();
    tick(2);
    chk({name, "_busy"}, busy, 1);
    while (done_cnt == start && n < BUDGET) begin tick(1); n++; end
    chk({name, "_done_seen"}, done_cnt - start, 1);
    tick(1);
    chk({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int start;
    rst_n_in = 1'b0;
    trigger_in = 1'b0;
    abort_in = 1'b0;
    set_all(0, 0, 0, 0, 8);
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_delay", delay_out, 0);
    chk("rst_valid", delay_valid, 0);
    chk("rst_amp", amp_out, 0);
    tick(2);
    rst_n_in = 1'b1;
    tick(2);

    chk("model_112", onset_of(100, 1000, 8), 112);
    chk("model_208", onset_of(200, 1000, 8), 208);
    chk("model_96", onset_of(90, 1000, 8), 96);
    chk("model_silent", onset_of(0, 1000, 8), 0);
    chk("model_fullscale", onset_of(97, -32768, 16), 112);

    // Two channels, bursts at 100 / 200 every round.
    set_all(100, 200, 1000, 1000, 8);
    run_scenario("basic");
    chk("basic_d0", dly(0), 112);
    chk("basic_d1", dly(1), 208);
    chk("basic_valid", delay_valid, 2'b11);
    chk("basic_timeout", timeout, 0);

    // Silence: every round misses until the round limit.
    set_all(0, 0, 0, 0, 8);
    run_scenario("silence");
    chk("silence_timeout", timeout, 1);
    chk("silence_valid", delay_valid, 0);

    // ch0 onset moves 96 -> 112 after round 1; confirmation needs round 4.
    set_all(100, 200, 1000, 1000, 8);
    plan_b[1][0] = 90;
    run_scenario("tol");
    chk("tol_rounds", imp_total - base, 4);
    chk("tol_d0", dly(0), 112);

    // Abort during round 4 analysis after ch0 confirmed in round 3.
    set_all(100, 0, 1000, 0, 8);
    start = done_cnt;
    trigger();
    wait_rs("abort", 4, 50);
    chk("abort_busy_before", busy, 1);
    abort_in = 1'b1;
    tick(1);
    abort_in = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", delay_valid, 2'b01);
    chk("abort_d0", dly(0), 112);
    tick(3000);
    chk("abort_no_done", done_cnt - start, 0);

    // Reset during the final holdoff, then a fresh full run.
    set_all(100, 200, 1000, 1000, 8);
    run_model();
    start = done_cnt;
    trigger();
    wait_rs("rsthold", 3, 208);
    tick(3);
    chk("rsthold_valid_before", delay_valid, 2'b11);
    #1 rst_n_in = 1'b0;
    #1;
    chk("rsthold_busy", busy, 0);
    chk("rsthold_done", done, 0);
    chk("rsthold_timeout", timeout, 0);
    chk("rsthold_delay", delay_out, 0);
    chk("rsthold_valid", delay_valid, 0);
    chk("rsthold_amp", amp_out, 0);
    tick(3);
    rst_n_in = 1'b1;
    tick(300);
    chk("rsthold_no_done", done_cnt - start, 0);
    run_scenario("after_rst");
    chk("after_rst_d1", dly(1), 208);

    // Full-scale negative samples filling a whole window.
    set_all(97, 193, -32768, -32768, 16);
    run_scenario("fullscale");
    chk("fullscale_d0", dly(0), 112);
    chk("fullscale_d1", dly(1), 208);
    chk("fullscale_valid", delay_valid, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
